cic_decimator_n: RTL and testbench

- Parametrised N-stage CIC decimator; successor to the fixed 1-bit-in / 24-bit-out CIC with its separate dec_clk.
- Single clock domain with an internal decimation counter; no second clock.
- Handles 1-bit PDM bitstreams (IN_W=1) or multi-bit two's-complement samples.
- Sits between the modulator/bitstream source and downstream FIR/compensation filtering, using a valid/strobe interface.

---
 rtl/cic_pkg.sv | 31 +++
 rtl/cic_comb_stage.sv | 55 +++++
 rtl/cic_decimator_n.sv | 151 +++++++++++++++
 tb/tb_cic_decimator_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator.
// Holds the width helpers used to size the counter and accumulators, and the
// signed codes that a 1-bit PDM stream is mapped to before integration.
package cic_pkg;

  // Bitstream mapping: a '1' contributes +1 and a '0' contributes -1.
  localparam logic signed [1:0] CIC_BIT_POS = 2'sb01;
  localparam logic signed [1:0] CIC_BIT_NEG = 2'sb11;

  // Ceiling log2, with a minimum result of 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Accumulator width that keeps the full CIC gain R^N without loss.
  function automatic int cic_acc_w(input int order, input int ratio, input int in_w);
    int in_eff;
    in_eff = (in_w == 1) ? 2 : in_w;
    return in_eff + order * clog2(ratio);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One differentiator (comb) stage of the CIC decimator.
// A token marks the cycle in which x_i carries a fresh decimated value; only
// then does the stage compute y = x - x_prev and remember x. The token and the
// result are both registered, so each stage adds exactly one clock of latency.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   x_i, tok_i : incoming value and its token
//   y_o, tok_o : registered difference and token, one cycle later
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] x_i,
  input  logic             tok_i,
  output logic [ACC_W-1:0] y_o,
  output logic             tok_o
);

  logic [ACC_W-1:0] prev_q, prev_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             tok_q;

  // Next-state: differentiate and update the delay only when the token is here.
  always_comb begin
    prev_d = prev_q;
    y_d    = y_q;
    if (tok_i) begin
      y_d    = x_i - prev_q;
      prev_d = x_i;
    end else begin
      y_d    = y_q;
      prev_d = prev_q;
    end
  end

  // State registers; the token always moves on so it never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= {ACC_W{1'b0}};
      y_q    <= {ACC_W{1'b0}};
      tok_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      y_q    <= y_d;
      tok_q  <= tok_i;
    end
  end

  assign y_o   = y_q;
  assign tok_o = tok_q;

endmodule

// File: rtl/cic_decimator_n.sv
// Parametrised N-stage CIC decimator, single clock domain.
// Integrators run on accepted input samples; every DEC_RATIO-th sample the
// last integrator is captured and a token carries it through ORDER comb
// stages and a final output register (ORDER+1 clocks after the tick).
// Optional build macro: CIC_ROUND_EN (round half up instead of truncating
// when the accumulator is wider than the output).
// Ports:
//   clk       : sample clock
//   rst       : asynchronous active-low reset
//   in_valid  : input strobe, integrators/counter advance only when high
//   in        : input sample (1-bit PDM or two's complement)
//   out_valid : one-cycle pulse on each new output
//   out       : decimated output, held between pulses
//   dec_phase : decimation counter value
module cic_decimator_n
  import cic_pkg::*;
#(
  parameter int ORDER     = 3,
  parameter int DEC_RATIO = 64,
  parameter int IN_W      = 1,
  parameter int OUT_W     = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out,
  output logic [clog2(DEC_RATIO)-1:0] dec_phase
);

  localparam int CNT_W = clog2(DEC_RATIO);
  localparam int ACC_W = cic_acc_w(ORDER, DEC_RATIO, IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_RATIO - 1);

  logic [ACC_W-1:0] in_ext_s;
  logic [ACC_W-1:0] integ_q [ORDER];
  logic [ACC_W-1:0] integ_d [ORDER];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;
  logic [ACC_W-1:0] dec_q, dec_d;
  logic             tok_q;
  logic [ACC_W-1:0] comb_x [ORDER+1];
  logic             comb_t [ORDER+1];
  logic [OUT_W-1:0] scaled_s;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q;

  // Map the input to a sign-extended accumulator-width value.
  if (IN_W == 1) begin : g_bit_in
    assign in_ext_s = in[0] ? {{(ACC_W-2){CIC_BIT_POS[1]}}, CIC_BIT_POS}
                            : {{(ACC_W-2){CIC_BIT_NEG[1]}}, CIC_BIT_NEG};
  end else begin : g_word_in
    assign in_ext_s = {{(ACC_W-IN_W){in[IN_W-1]}}, in};
  end

  assign tick_s = in_valid && (cnt_q == CNT_LAST);

  // Next-state for integrators, counter and decimation capture. Each stage
  // adds the previous stage's registered value; wrap-around is intentional.
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      integ_d[k] = integ_q[k];
    end
    cnt_d = cnt_q;
    if (in_valid) begin
      integ_d[0] = integ_q[0] + in_ext_s;
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    dec_d = tick_s ? integ_q[ORDER-1] : dec_q;
  end

  // Integrator, counter and decimation registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= {ACC_W{1'b0}};
      end
      cnt_q <= {CNT_W{1'b0}};
      dec_q <= {ACC_W{1'b0}};
      tok_q <= 1'b0;
    end else begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
      end
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      tok_q <= tick_s;
    end
  end

  assign comb_x[0] = dec_q;
  assign comb_t[0] = tok_q;

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(.ACC_W(ACC_W)) u_comb (
      .clk   (clk),
      .rst_n (rst),
      .x_i   (comb_x[g]),
      .tok_i (comb_t[g]),
      .y_o   (comb_x[g+1]),
      .tok_o (comb_t[g+1])
    );
  end

  // Scale the comb result to the output width (keep the MSBs when narrowing).
  if (ACC_W > OUT_W) begin : g_narrow
`ifdef CIC_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W - OUT_W - 1);
    logic [ACC_W-1:0] rounded_s;
    assign rounded_s = comb_x[ORDER] + HALF;
    assign scaled_s  = rounded_s[ACC_W-1 -: OUT_W];
`else
    assign scaled_s = comb_x[ORDER][ACC_W-1 -: OUT_W];
`endif
  end else if (ACC_W == OUT_W) begin : g_equal
    assign scaled_s = comb_x[ORDER];
  end else begin : g_widen
    assign scaled_s = {{(OUT_W-ACC_W){comb_x[ORDER][ACC_W-1]}}, comb_x[ORDER]};
  end

  // Output hold value: load only when the token leaves the last comb stage.
  always_comb begin
    if (comb_t[ORDER]) begin
      out_d = scaled_s;
    end else begin
      out_d = out_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= comb_t[ORDER];
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign dec_phase = cnt_q;

endmodule

// File: tb/tb_cic_decimator_n.sv
// Self-checking bench for cic_decimator_n: a 3rd-order R=64 PDM instance (A)
// and a 1st-order R=2 8-bit instance (B). Expected outputs and their arrival
// cycle are queued when the tick-producing sample is driven and popped when
// out_valid is seen.
module tb_cic_decimator_n;

  localparam int A_ORDER = 3;
  localparam int A_R     = 64;
  localparam int B_ORDER = 1;
  localparam int B_R     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b0;
  logic        a_iv = 1'b0;
  logic [0:0]  a_in = 1'b0;
  logic        a_ov;
  logic [23:0] a_out;
  logic [5:0]  a_ph;
  logic        b_iv = 1'b0;
  logic [7:0]  b_in = 8'd0;
  logic        b_ov;
  logic [7:0]  b_out;
  logic [0:0]  b_ph;

  typedef struct {
    logic [23:0] val;
    bit          chk;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int a_ph_m = 0, b_ph_m = 0, a_outs = 0, b_outs = 0;
  logic [23:0] a_exp = 24'd0;
  logic [7:0]  b_exp = 8'd0;

  cic_decimator_n #(.ORDER(A_ORDER), .DEC_RATIO(A_R), .IN_W(1), .OUT_W(24)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in(a_in),
    .out_valid(a_ov), .out(a_out), .dec_phase(a_ph)
  );

  cic_decimator_n #(.ORDER(B_ORDER), .DEC_RATIO(B_R), .IN_W(8), .OUT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in(b_in),
    .out_valid(b_ov), .out(b_out), .dec_phase(b_ph)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop on every out_valid, check arrival cycle and value.
  always @(negedge clk) begin
    exp_t e;
    if (a_ov === 1'b1) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_mis++;
        $display("FAIL a_stray_pulse at cyc %0d out=%h (no pulse expected)", cyc, a_out);
      end else begin
        e = qa.pop_front();
        if (cyc != e.due) begin
          n_mis++;
          $display("FAIL a_pulse_time got cyc %0d want %0d", cyc, e.due);
        end
        if (e.chk) begin
          n_cmp++;
          if (a_out !== e.val) begin
            n_mis++;
            $display("FAIL a_out_value got %h want %h", a_out, e.val);
          end
        end
      end
    end
    if (qa.size() > 0 && qa[0].due < cyc) begin
      n_cmp++; n_mis++;
      $display("FAIL a_missing_pulse due %0d now %0d", qa[0].due, cyc);
      void'(qa.pop_front());
    end
    if (b_ov === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_mis++;
        $display("FAIL b_stray_pulse at cyc %0d out=%h (no pulse expected)", cyc, b_out);
      end else begin
        e = qb.pop_front();
        if (cyc != e.due) begin
          n_mis++;
          $display("FAIL b_pulse_time got cyc %0d want %0d", cyc, e.due);
        end
        if (e.chk) begin
          n_cmp++;
          if (b_out !== e.val[7:0]) begin
            n_mis++;
            $display("FAIL b_out_value got %h want %h", b_out, e.val[7:0]);
          end
        end
      end
    end
    if (qb.size() > 0 && qb[0].due < cyc) begin
      n_cmp++; n_mis++;
      $display("FAIL b_missing_pulse due %0d now %0d", qb[0].due, cyc);
      void'(qb.pop_front());
    end
  end

  // Drive one A sample (call at a negedge while rst=1) and model the counter.
  task automatic drive_a(input logic v, input logic d);
    exp_t e;
    a_iv = v;
    a_in = d;
    if (v) begin
      if (a_ph_m == A_R - 1) begin
        e.val = a_exp;
        e.chk = (a_outs >= A_ORDER);
        e.due = cyc + A_ORDER + 2;
        qa.push_back(e);
        a_outs++;
        a_ph_m = 0;
      end else begin
        a_ph_m++;
      end
    end
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d);
    exp_t e;
    b_iv = v;
    b_in = d;
    if (v) begin
      if (b_ph_m == B_R - 1) begin
        e.val = {16'd0, b_exp};
        e.chk = (b_outs >= B_ORDER);
        e.due = cyc + B_ORDER + 2;
        qb.push_back(e);
        b_outs++;
        b_ph_m = 0;
      end else begin
        b_ph_m++;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    a_iv = 1'b0;
    b_iv = 1'b0;
    qa.delete(); qb.delete();
    a_ph_m = 0; b_ph_m = 0; a_outs = 0; b_outs = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (a_out !== 24'd0) begin n_mis++; $display("FAIL rst_a_out got %h want 000000", a_out); end
    if (a_ov !== 1'b0)   begin n_mis++; $display("FAIL rst_a_valid got %b want 0", a_ov); end
    if (a_ph !== 6'd0)   begin n_mis++; $display("FAIL rst_a_phase got %0d want 0", a_ph); end
    if (b_out !== 8'd0)  begin n_mis++; $display("FAIL rst_b_out got %h want 00", b_out); end
    if (b_ov !== 1'b0)   begin n_mis++; $display("FAIL rst_b_valid got %b want 0", b_ov); end
    if (b_ph !== 1'b0)   begin n_mis++; $display("FAIL rst_b_phase got %0d want 0", b_ph); end
    rst = 1'b1;
  endtask

  // mode 0: constant 1, mode 1: constant 0, mode 2: alternating 1,0.
  task automatic test_pattern(input int mode, input logic [23:0] want);
    apply_reset();
    a_exp = want;
    for (int i = 0; i < 7 * A_R; i++) begin
      @(negedge clk);
      drive_a(1'b1, (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((i % 2) == 0));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a(1'b0, 1'b0);
    end
    n_cmp += 2;
    if (qa.size() != 0) begin n_mis++; $display("FAIL pat%0d_drain got %0d pending want 0", mode, qa.size()); end
    if (a_out !== want) begin n_mis++; $display("FAIL pat%0d_hold got %h want %h", mode, a_out, want); end
  endtask

  task automatic test_gaps();
    int i;
    apply_reset();
    a_exp = 24'h040000;
    i = 0;
    while (a_outs < 6 && i < 4000) begin
      @(negedge clk);
      n_cmp++;
      if (a_ph !== a_ph_m[5:0]) begin
        n_mis++;
        $display("FAIL gap_phase got %0d want %0d", a_ph, a_ph_m);
      end
      drive_a((i % 20) < 10, 1'b1);
      i++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive_a(1'b0, 1'b0);
    end
    n_cmp += 2;
    if (a_outs < 6)     begin n_mis++; $display("FAIL gap_ticks got %0d want 6", a_outs); end
    if (qa.size() != 0) begin n_mis++; $display("FAIL gap_drain got %0d pending want 0", qa.size()); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    a_exp = 24'h040000;
    for (int i = 0; i < 5 * A_R; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b1);
    end
    @(negedge clk); drive_a(1'b1, 1'b1);
    @(negedge clk); drive_a(1'b1, 1'b1);
    #2;
    rst = 1'b0;
    qa.delete();
    a_ph_m = 0; a_outs = 0;
    #1;
    n_cmp += 3;
    if (a_out !== 24'd0) begin n_mis++; $display("FAIL mid_rst_out got %h want 000000", a_out); end
    if (a_ov !== 1'b0)   begin n_mis++; $display("FAIL mid_rst_valid got %b want 0", a_ov); end
    if (a_ph !== 6'd0)   begin n_mis++; $display("FAIL mid_rst_phase got %0d want 0", a_ph); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_a(1'b1, 1'b1);
    for (int i = 1; i < 2 * A_R; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive_a(1'b0, 1'b0);
    end
    n_cmp++;
    if (qa.size() != 0) begin n_mis++; $display("FAIL mid_rst_drain got %0d pending want 0", qa.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
`ifdef CIC_ROUND_EN
    b_exp = 8'd2;
`else
    b_exp = 8'd1;
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_b(1'b1, ((i % 2) == 0) ? 8'd1 : 8'd2);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_b(1'b0, 8'd0);
    end
    n_cmp += 2;
    if (qb.size() != 0) begin n_mis++; $display("FAIL b2b_drain got %0d pending want 0", qb.size()); end
    if (b_out !== b_exp) begin n_mis++; $display("FAIL b2b_hold got %h want %h", b_out, b_exp); end
  endtask

  initial begin
    test_reset();
    test_pattern(0, 24'h040000);
    test_pattern(1, 24'hFC0000);
    test_pattern(2, 24'h000000);
    test_gaps();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
